mux_piso_ctrl: RTL and testbench

Sequencer that sits directly around the 8:1 mux stage (mux_8x1) and turns it into a parallel-in/serial-out path. It accepts one byte per frame over a valid/ready handshake and drives the mux data (`mux_a`) and select (`mux_sel`) inputs. It registers the mux output (`mux_y`) into a serial bit stream with valid/ready backpressure and end-of-frame marking. Back-to-back frames stream with no idle gap.

---
 rtl/mux_piso_ctrl_if.sv | 21 ++
 rtl/mux_piso_ctrl.sv | 95 +++++++++
 tb/tb_mux_piso_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mux_piso_ctrl_if.sv
// Byte-in / bit-out handshake bundle for mux_piso_ctrl.
// slave is the sequencer's view; master is the producer/consumer side around it.
interface mux_piso_ctrl_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       ser_bit;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_last;

  modport slave (
    input  din, din_valid, ser_ready,
    output din_ready, ser_bit, ser_valid, ser_last
  );

  modport master (
    output din, din_valid, ser_ready,
    input  din_ready, ser_bit, ser_valid, ser_last
  );
endinterface

// File: rtl/mux_piso_ctrl.sv
// Parallel-in/serial-out sequencer wrapped around an external 8:1 mux.
// Define MUX_PISO_MSB_FIRST_EN for MSB-first bit order (default LSB first).
module mux_piso_ctrl #(
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_piso_ctrl_if.slave        io,
  output logic [7:0]            mux_a,
  output logic [2:0]            mux_sel,
  input  logic                  mux_y,
  output logic                  busy
);
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] a_n;
  logic       bit_q, bit_n, vld_q, vld_n, last_q, last_n;
  logic       adv, accept;

  assign adv          = ~vld_q | io.ser_ready;
  assign io.din_ready = (state == IDLE) | ((state == SHIFT) & (cnt == 3'd7) & adv);
  assign accept       = io.din_valid & io.din_ready;

`ifdef MUX_PISO_MSB_FIRST_EN
  assign mux_sel = ~cnt;
`else
  assign mux_sel = cnt;
`endif

  assign io.ser_bit   = bit_q;
  assign io.ser_valid = vld_q;
  assign io.ser_last  = last_q;
  assign busy         = (state == SHIFT) | vld_q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    a_n     = mux_a;
    bit_n   = bit_q;
    vld_n   = vld_q;
    last_n  = last_q;
    case (state)
      IDLE: begin
        // Drain a stalled last bit even on the edge a new byte lands,
        // otherwise that bit would be presented twice.
        if (adv) begin
          vld_n  = 1'b0;
          bit_n  = IDLE_VAL;
          last_n = 1'b0;
        end
        if (accept) begin
          a_n     = io.din;
          cnt_n   = 3'd0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (adv) begin
          bit_n  = mux_y;
          vld_n  = 1'b1;
          last_n = (cnt == 3'd7);
          if (cnt != 3'd7) begin
            cnt_n = cnt + 3'd1;
          end else if (accept) begin
            a_n   = io.din;
            cnt_n = 3'd0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      mux_a  <= 8'h00;
      bit_q  <= IDLE_VAL;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      mux_a  <= a_n;
      bit_q  <= bit_n;
      vld_q  <= vld_n;
      last_q <= last_n;
    end
  end
endmodule

// File: tb/tb_mux_piso_ctrl.sv
// Directed bench for mux_piso_ctrl with an 8:1 mux closing the loop.
module tb_mux_piso_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_piso_ctrl_if bus0 ();
  mux_piso_ctrl_if bus1 ();

  logic [7:0] mux_a0, mux_a1;
  logic [2:0] mux_sel0, mux_sel1;
  logic       mux_y0, mux_y1, busy0, busy1;

  assign mux_y0 = mux_a0[mux_sel0];
  assign mux_y1 = mux_a1[mux_sel1];

  mux_piso_ctrl #(.IDLE_VAL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .io(bus0.slave),
    .mux_a(mux_a0), .mux_sel(mux_sel0), .mux_y(mux_y0), .busy(busy0)
  );

  mux_piso_ctrl #(.IDLE_VAL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .io(bus1.slave),
    .mux_a(mux_a1), .mux_sel(mux_sel1), .mux_y(mux_y1), .busy(busy1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Hand-computed serial sequences: bit i is the bit registered at T(i+1).
`ifdef MUX_PISO_MSB_FIRST_EN
  localparam logic [7:0]  SEQ_1E   = 8'b0111_1000;
  localparam logic [15:0] SEQ_0FF0 = 16'h0FF0;
  localparam logic [7:0]  SEQ_01   = 8'h80;
`else
  localparam logic [7:0]  SEQ_1E   = 8'b0001_1110;
  localparam logic [15:0] SEQ_0FF0 = 16'hF00F;
  localparam logic [7:0]  SEQ_01   = 8'h01;
`endif
  localparam logic [7:0]  SEQ_A5   = 8'hA5;

  function automatic logic [2:0] sel_of(input int i);
`ifdef MUX_PISO_MSB_FIRST_EN
    return 3'(7 - i);
`else
    return 3'(i);
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle0(input string tag);
    check({tag, ".ser_valid"}, 16'(bus0.ser_valid), 16'd0);
    check({tag, ".ser_bit"},   16'(bus0.ser_bit),   16'd0);
    check({tag, ".ser_last"},  16'(bus0.ser_last),  16'd0);
    check({tag, ".busy"},      16'(busy0),          16'd0);
    check({tag, ".din_ready"}, 16'(bus0.din_ready), 16'd1);
  endtask

  initial begin
    bus0.din = 8'h00; bus0.din_valid = 1'b0; bus0.ser_ready = 1'b1;
    bus1.din = 8'h00; bus1.din_valid = 1'b0; bus1.ser_ready = 1'b1;
    #2;
    chk_idle0("reset");
    check("reset.mux_a",   16'(mux_a0),   16'h00);
    check("reset.mux_sel", 16'(mux_sel0), 16'(sel_of(0)));
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single frame 8'h1E
    bus0.din = 8'h1E; bus0.din_valid = 1'b1;
    tick();
    bus0.din_valid = 1'b0;
    check("f1e.mux_a", 16'(mux_a0), 16'h1E);
    check("f1e.din_ready_busy", 16'(bus0.din_ready), 16'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("f1e.sel%0d", i), 16'(mux_sel0), 16'(sel_of(i)));
      tick();
      check($sformatf("f1e.valid%0d", i), 16'(bus0.ser_valid), 16'd1);
      check($sformatf("f1e.bit%0d", i),   16'(bus0.ser_bit),   16'(SEQ_1E[i]));
      check($sformatf("f1e.last%0d", i),  16'(bus0.ser_last),  16'(i == 7));
    end
    tick();
    chk_idle0("f1e.t9");

    // Back-to-back 8'h0F then 8'hF0 with din_valid held
    bus0.din = 8'h0F; bus0.din_valid = 1'b1;
    tick();
    bus0.din = 8'hF0;
    for (int j = 0; j < 16; j++) begin
      if (j == 7) check("b2b.din_ready_t8", 16'(bus0.din_ready), 16'd1);
      tick();
      if (j == 7) bus0.din_valid = 1'b0;
      check($sformatf("b2b.valid%0d", j), 16'(bus0.ser_valid), 16'd1);
      check($sformatf("b2b.bit%0d", j),   16'(bus0.ser_bit),   16'(SEQ_0FF0[j]));
      check($sformatf("b2b.last%0d", j),  16'(bus0.ser_last),  16'(j == 7 || j == 15));
    end
    tick();
    chk_idle0("b2b.end");

    // Backpressure: 3-cycle stall while the second bit is presented
    bus0.din = 8'hA5; bus0.din_valid = 1'b1;
    tick();
    bus0.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("bp.bit%0d", i),   16'(bus0.ser_bit),   16'(SEQ_A5[i]));
      check($sformatf("bp.valid%0d", i), 16'(bus0.ser_valid), 16'd1);
      check($sformatf("bp.last%0d", i),  16'(bus0.ser_last),  16'(i == 7));
      if (i == 1) begin
        bus0.ser_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          check($sformatf("bp.hold_bit%0d", k),   16'(bus0.ser_bit),   16'(SEQ_A5[1]));
          check($sformatf("bp.hold_valid%0d", k), 16'(bus0.ser_valid), 16'd1);
          check($sformatf("bp.hold_sel%0d", k),   16'(mux_sel0),       16'(sel_of(2)));
          check($sformatf("bp.hold_busy%0d", k),  16'(busy0),          16'd1);
        end
        bus0.ser_ready = 1'b1;
      end
    end
    tick();
    chk_idle0("bp.end");

    // Reset mid-frame after 4 bits of 8'hFF
    bus0.din = 8'hFF; bus0.din_valid = 1'b1;
    tick();
    bus0.din_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rmid.pre_valid", 16'(bus0.ser_valid), 16'd1);
    check("rmid.pre_bit",   16'(bus0.ser_bit),   16'd1);
    #2 rst = 1'b1;
    #1;
    chk_idle0("rmid.async");
    check("rmid.mux_a",   16'(mux_a0),   16'h00);
    check("rmid.mux_sel", 16'(mux_sel0), 16'(sel_of(0)));
    tick();
    rst = 1'b0;
    tick();
    bus0.din = 8'h01; bus0.din_valid = 1'b1;
    tick();
    bus0.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("r01.sel%0d", i), 16'(mux_sel0), 16'(sel_of(i)));
      tick();
      check($sformatf("r01.bit%0d", i),  16'(bus0.ser_bit),  16'(SEQ_01[i]));
      check($sformatf("r01.last%0d", i), 16'(bus0.ser_last), 16'(i == 7));
    end
    tick();
    chk_idle0("r01.end");

    // IDLE_VAL = 1 instance, never fed a byte
    check("iv1.ser_bit",   16'(bus1.ser_bit),   16'd1);
    check("iv1.ser_valid", 16'(bus1.ser_valid), 16'd0);
    check("iv1.busy",      16'(busy1),          16'd0);
    check("iv1.din_ready", 16'(bus1.din_ready), 16'd1);
    check("iv1.ser_last",  16'(bus1.ser_last),  16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
